// File: rtl/mag_accum_pkg.sv
// Shared widths and FSM encoding for the magnitude block accumulator.
// Imported by the interface, the top and the peak tracker.
package mag_accum_pkg;

    localparam int MAG_W = 7;
    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        HOLD
    } state_t;

endpackage

// File: rtl/mag_accum_if.sv
// Sample-in / result-out handshake bundle for mag_accum.
// master = producer/consumer side, slave = the accumulator.
interface mag_accum_if #(
    parameter int ACC_W = 11
) ();
    import mag_accum_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [MAG_W-1:0] in_mag;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic [CNT_W-1:0] out_len;
    logic [MAG_W-1:0] out_peak;

    modport master (
        output in_valid,
        output in_mag,
        output flush,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_sum,
        input  out_len,
        input  out_peak
    );

    modport slave (
        input  in_valid,
        input  in_mag,
        input  flush,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_sum,
        output out_len,
        output out_peak
    );

endinterface

// File: rtl/mag_peak.sv
// Running-maximum register for one accumulation block.
// Only exists when MAG_ACCUM_PEAK_EN is defined.
`ifdef MAG_ACCUM_PEAK_EN
module mag_peak
    import mag_accum_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic             i_update,
    input  logic             i_clear,
    input  logic [MAG_W-1:0] i_mag,
    output logic [MAG_W-1:0] o_peak
);

    logic [MAG_W-1:0] r_peak;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_peak <= '0;
        end else if (i_clear) begin
            r_peak <= '0;
        end else if (i_load) begin
            r_peak <= i_mag;
        end else if (i_update && (i_mag > r_peak)) begin
            r_peak <= i_mag;
        end
    end

    assign o_peak = r_peak;

endmodule
`endif

// File: rtl/mag_accum.sv
// Block accumulator: sums BLOCK_LEN magnitudes (saturating), holds result.
// Define MAG_ACCUM_PEAK_EN to also report the per-block peak magnitude.
module mag_accum
    import mag_accum_pkg::*;
#(
    parameter int BLOCK_LEN = 16,
    parameter int ACC_W     = 11
) (
    input  logic         clk,
    input  logic         rst_n,
    mag_accum_if.slave   bus
);

    state_t           r_state;
    state_t           w_next;
    logic [ACC_W-1:0] r_sum;
    logic [CNT_W-1:0] r_cnt;

    logic             w_in_ready;
    logic             w_accept;
    logic             w_load;
    logic             w_upd;
    logic             w_clr;
    logic             w_last;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [ACC_W:0]   w_sum_add;
    logic [ACC_W-1:0] w_sum_sat;
    logic [MAG_W-1:0] w_peak;
    logic             w_hold;

    assign w_hold     = (r_state == HOLD);
    assign w_in_ready = !w_hold;
    assign w_accept   = bus.in_valid && w_in_ready;

    assign w_cnt_inc = (r_state == IDLE) ? CNT_W'(1) : r_cnt + 1'b1;
    assign w_last    = w_accept && (w_cnt_inc == CNT_W'(BLOCK_LEN));

    // One spare carry bit detects overflow so the sum clamps instead of wrapping
    assign w_sum_add = {1'b0, r_sum}
                     + {{(ACC_W + 1 - MAG_W){1'b0}}, bus.in_mag};
    assign w_sum_sat = w_sum_add[ACC_W] ? '1 : w_sum_add[ACC_W-1:0];

    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        w_upd  = 1'b0;
        w_clr  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_load = 1'b1;
                    w_next = (w_last || bus.flush) ? HOLD : ACCUM;
                end
            end
            ACCUM: begin
                w_upd = w_accept;
                if (w_last || bus.flush) begin
                    w_next = HOLD;
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    w_next = IDLE;
                    w_clr  = 1'b1;
                end
            end
            default: begin
                w_next = IDLE;
                w_clr  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_sum   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (w_load) begin
                r_sum <= {{(ACC_W - MAG_W){1'b0}}, bus.in_mag};
                r_cnt <= CNT_W'(1);
            end else if (w_upd) begin
                r_sum <= w_sum_sat;
                r_cnt <= w_cnt_inc;
            end else if (w_clr) begin
                r_sum <= '0;
                r_cnt <= '0;
            end
        end
    end

`ifdef MAG_ACCUM_PEAK_EN
    mag_peak u_peak (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_load   (w_load),
        .i_update (w_upd),
        .i_clear  (w_clr),
        .i_mag    (bus.in_mag),
        .o_peak   (w_peak)
    );
`else
    assign w_peak = '0;
`endif

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_hold;
    assign bus.out_sum   = w_hold ? r_sum  : '0;
    assign bus.out_len   = w_hold ? r_cnt  : '0;
    assign bus.out_peak  = w_hold ? w_peak : '0;

endmodule

// File: tb/tb_mag_accum.sv
// Testbench for mag_accum: two instances (BLOCK_LEN=4/ACC_W=11 and
// BLOCK_LEN=16/ACC_W=8) share one stimulus stream and a behavioural model.
module tb_mag_accum;

`ifdef MAG_ACCUM_PEAK_EN
    localparam bit PK_EN = 1'b1;
`else
    localparam bit PK_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       s_valid;
    logic [6:0] s_mag;
    logic       s_flush;
    logic       s_ordy;
    bit         chk_en = 1'b0;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mag_accum_if #(.ACC_W(11)) if0 ();
    mag_accum_if #(.ACC_W(8))  if1 ();

    assign if0.in_valid  = s_valid;
    assign if0.in_mag    = s_mag;
    assign if0.flush     = s_flush;
    assign if0.out_ready = s_ordy;
    assign if1.in_valid  = s_valid;
    assign if1.in_mag    = s_mag;
    assign if1.flush     = s_flush;
    assign if1.out_ready = s_ordy;

    mag_accum #(.BLOCK_LEN(4), .ACC_W(11)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if0.slave)
    );

    mag_accum #(.BLOCK_LEN(16), .ACC_W(8)) u_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1.slave)
    );

    // Model: unbounded sum of the block; clamp only when reporting
    int m_held[2];
    int m_cnt[2];
    int m_sum[2];
    int m_pk[2];

    function automatic int bl(input int k);
        return (k == 0) ? 4 : 16;
    endfunction

    function automatic int smax(input int k);
        return (k == 0) ? 2047 : 255;
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                m_held[k] <= 0;
                m_cnt[k]  <= 0;
                m_sum[k]  <= 0;
                m_pk[k]   <= 0;
            end else if (m_held[k] != 0) begin
                if (s_ordy) begin
                    m_held[k] <= 0;
                    m_cnt[k]  <= 0;
                    m_sum[k]  <= 0;
                    m_pk[k]   <= 0;
                end
            end else begin
                if (s_valid) begin
                    m_cnt[k] <= m_cnt[k] + 1;
                    m_sum[k] <= m_sum[k] + int'(s_mag);
                    m_pk[k]  <= (int'(s_mag) > m_pk[k]) ? int'(s_mag) : m_pk[k];
                end
                if ((s_valid && (m_cnt[k] + 1 == bl(k))) ||
                    (s_flush && (s_valid || m_cnt[k] > 0)))
                    m_held[k] <= 1;
            end
        end
    end

    task automatic lit(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    task automatic cmp(input int k, input logic v, input logic r,
                       input logic [31:0] s, input logic [31:0] l,
                       input logic [31:0] p);
        logic [31:0] es;
        logic [31:0] el;
        logic [31:0] ep;
        bit h;
        h  = (m_held[k] != 0);
        es = h ? ((m_sum[k] > smax(k)) ? smax(k) : m_sum[k]) : 0;
        el = h ? m_cnt[k] : 0;
        ep = (h && PK_EN) ? m_pk[k] : 0;
        lit($sformatf("dut%0d out_valid", k), {31'd0, v}, {31'd0, h});
        lit($sformatf("dut%0d in_ready", k),  {31'd0, r}, {31'd0, !h});
        lit($sformatf("dut%0d out_sum", k),   s, es);
        lit($sformatf("dut%0d out_len", k),   l, el);
        lit($sformatf("dut%0d out_peak", k),  p, ep);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp(0, if0.out_valid, if0.in_ready, 32'(if0.out_sum),
                32'(if0.out_len), 32'(if0.out_peak));
            cmp(1, if1.out_valid, if1.in_ready, 32'(if1.out_sum),
                32'(if1.out_len), 32'(if1.out_peak));
        end
    end

    task automatic cyc(input bit v, input int m, input bit f, input bit r);
        s_valid = v;
        s_mag   = 7'(m);
        s_flush = f;
        s_ordy  = r;
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_mag   = '0;
        s_flush = 1'b0;
        s_ordy  = 1'b1;
        cyc(0, 0, 0, 1);
        cyc(1, 77, 1, 1);
        chk_en = 1'b1;
        lit("reset out_valid", {31'd0, if0.out_valid}, 0);
        lit("reset in_ready", {31'd0, if0.in_ready}, 1);
        lit("reset out_len", 32'(if0.out_len), 0);
        rst_n = 1'b1;

        // Full block of four, consumer always ready
        cyc(1, 10, 0, 1);
        cyc(1, 20, 0, 1);
        cyc(1, 30, 0, 1);
        cyc(1, 40, 0, 1);
        lit("blk4 out_valid", {31'd0, if0.out_valid}, 1);
        lit("blk4 out_sum", 32'(if0.out_sum), 100);
        lit("blk4 out_len", 32'(if0.out_len), 4);
        lit("blk4 out_peak", 32'(if0.out_peak), PK_EN ? 40 : 0);
        cyc(0, 0, 0, 1);
        lit("blk4 idle valid", {31'd0, if0.out_valid}, 0);
        lit("blk4 idle ready", {31'd0, if0.in_ready}, 1);

        // Flush with a same-cycle sample
        cyc(1, 5, 0, 1);
        cyc(1, 7, 0, 1);
        cyc(1, 3, 1, 1);
        lit("flush out_sum", 32'(if0.out_sum), 15);
        lit("flush out_len", 32'(if0.out_len), 3);
        lit("flush out_peak", 32'(if0.out_peak), PK_EN ? 7 : 0);
        cyc(0, 0, 0, 1);

        // Backpressure: result held while upstream keeps offering
        cyc(1, 1, 0, 0);
        cyc(1, 2, 0, 0);
        cyc(1, 3, 0, 0);
        cyc(1, 4, 0, 0);
        for (int i = 0; i < 5; i++) begin
            cyc(1, 99, 0, 0);
            lit("hold in_ready", {31'd0, if0.in_ready}, 0);
            lit("hold out_sum", 32'(if0.out_sum), 10);
            lit("hold out_len", 32'(if0.out_len), 4);
        end
        cyc(1, 99, 0, 1);
        lit("release valid", {31'd0, if0.out_valid}, 0);
        cyc(1, 9, 1, 1);
        lit("fresh out_sum", 32'(if0.out_sum), 9);
        lit("fresh out_len", 32'(if0.out_len), 1);
        cyc(0, 0, 0, 1);

        // Saturation on the narrow instance
        rst_n = 1'b0;
        cyc(1, 50, 1, 1);
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) cyc(1, 127, 0, 1);
        lit("sat out_valid", {31'd0, if1.out_valid}, 1);
        lit("sat out_sum", 32'(if1.out_sum), 255);
        lit("sat out_len", 32'(if1.out_len), 16);
        cyc(0, 0, 0, 1);

        // Reset mid-block discards the partial sum
        cyc(1, 8, 0, 1);
        cyc(1, 9, 0, 1);
        rst_n = 1'b0;
        cyc(1, 50, 0, 1);
        lit("midrst valid", {31'd0, if0.out_valid}, 0);
        lit("midrst ready", {31'd0, if0.in_ready}, 1);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) cyc(1, 1, 0, 1);
        lit("post-rst out_sum", 32'(if0.out_sum), 4);
        lit("post-rst out_len", 32'(if0.out_len), 4);
        cyc(0, 0, 0, 1);

        // Flush in IDLE without a sample is ignored
        cyc(0, 0, 1, 1);
        lit("idle flush valid", {31'd0, if0.out_valid}, 0);
        cyc(0, 0, 0, 1);
        lit("idle flush valid+1", {31'd0, if0.out_valid}, 0);

        for (int i = 0; i < 2000; i++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            cyc($urandom_range(0, 9) < 7,
                ($urandom_range(0, 3) == 0) ? 127 : int'($urandom_range(0, 127)),
                $urandom_range(0, 9) == 0,
                $urandom_range(0, 9) < 6);
        end
        rst_n = 1'b1;
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        chk_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
